// File: rtl/port_nack_buffer.sv
// Elastic token buffer in front of an ALU port synchroniser.
// Holds the head word under synchroniser Nack and back-pressures the link.
module port_nack_buffer #(
    parameter int WIDTH_DATA  = 32,
    parameter int DEPTH       = 8,
    parameter int WIDTH_DEPTH = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH_DATA-1:0]  I_Data,
    input  logic                   I_Valid,
    input  logic                   I_Acq,
    input  logic                   I_Rls,
    output logic                   O_Nack,
    output logic [WIDTH_DATA-1:0]  O_Data,
    output logic                   O_Valid,
    output logic                   O_Acq,
    output logic                   O_Rls,
    input  logic                   I_Nack_My,
    input  logic                   I_Flush,
    output logic                   O_Busy,
    output logic                   O_Overflow,
    output logic [WIDTH_DEPTH:0]   O_Count
);

    localparam int W = WIDTH_DATA + 2;
    localparam logic [WIDTH_DEPTH:0] FULL_C = DEPTH;
    localparam logic [WIDTH_DEPTH:0] NACK_C = DEPTH - 2;
    localparam logic [WIDTH_DEPTH:0] ONE_C  = 1;

    typedef enum logic [1:0] {
        iDLE,
        aCTIVE,
        rLS_PEND
    } state_t;

    logic [W-1:0]           mem_q [DEPTH];
    logic [WIDTH_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH_DEPTH:0]   count_q, count_d;
    logic [WIDTH_DEPTH:0]   rls_cnt_q, rls_cnt_d;
    logic                   nack_q, nack_d;
    logic                   ovf_q, ovf_d;
    state_t                 state_q, state_d;

    logic [W-1:0] head;
    logic         empty, full, pop, wr, drop;
    logic         rls_in, rls_out, rls_done;

    assign head     = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_C);
    assign pop      = ~empty & ~I_Nack_My;
    assign wr       = I_Valid & (~full | pop) & ~I_Flush;
    assign drop     = I_Valid & full & ~pop & ~I_Flush;
    assign rls_in   = wr & I_Rls;
    assign rls_out  = pop & head[W-1];
    // Last outstanding Rls leaves and no new one replaces it.
    assign rls_done = rls_out & ~rls_in & (rls_cnt_q == ONE_C);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rls_cnt_d = rls_cnt_q;
        state_d   = state_q;
        ovf_d     = ovf_q | drop;
        if (I_Flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rls_cnt_d = '0;
            state_d   = iDLE;
        end else begin
            if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            unique case ({rls_in, rls_out})
                2'b10:   rls_cnt_d = rls_cnt_q + ONE_C;
                2'b01:   rls_cnt_d = rls_cnt_q - ONE_C;
                default: rls_cnt_d = rls_cnt_q;
            endcase
            unique case (state_q)
                iDLE: begin
                    if (wr & I_Acq)
                        state_d = I_Rls ? rLS_PEND : aCTIVE;
                end
                aCTIVE: begin
                    if (rls_in) state_d = rLS_PEND;
                end
                rLS_PEND: begin
                    if (rls_done)
                        state_d = (wr & I_Acq) ? aCTIVE : iDLE;
                end
                default: state_d = iDLE;
            endcase
        end
        nack_d = ~I_Flush & (count_d >= NACK_C);
    end

    always_ff @(posedge clock) begin
        if (wr) mem_q[wr_ptr_q] <= {I_Rls, I_Acq, I_Data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rls_cnt_q <= '0;
            nack_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= iDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rls_cnt_q <= rls_cnt_d;
            nack_q    <= nack_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
        end
    end

    assign O_Valid    = ~empty;
    assign O_Data     = empty ? '0 : head[WIDTH_DATA-1:0];
    assign O_Acq      = ~empty & head[W-2];
    assign O_Rls      = ~empty & head[W-1];
    assign O_Nack     = nack_q;
    assign O_Overflow = ovf_q;
    assign O_Count    = count_q;
    assign O_Busy     = (state_q != iDLE) | ~empty;

endmodule

// File: tb/tb_port_nack_buffer.sv
// Directed scoreboard bench for port_nack_buffer (DEPTH=8).
// Inputs driven and outputs sampled on the falling edge.
module tb_port_nack_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] I_Data;
    logic        I_Valid, I_Acq, I_Rls, I_Nack_My, I_Flush;
    logic        O_Nack, O_Valid, O_Acq, O_Rls, O_Busy, O_Overflow;
    logic [31:0] O_Data;
    logic [3:0]  O_Count;

    int errors = 0;
    int checks = 0;
    logic [33:0] sb [$];
    int   mcount = 0;
    logic movf = 1'b0;
    logic mnack = 1'b0;

    port_nack_buffer #(.WIDTH_DATA(32), .DEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .I_Data(I_Data), .I_Valid(I_Valid),
        .I_Acq(I_Acq), .I_Rls(I_Rls),
        .O_Nack(O_Nack), .O_Data(O_Data),
        .O_Valid(O_Valid), .O_Acq(O_Acq), .O_Rls(O_Rls),
        .I_Nack_My(I_Nack_My), .I_Flush(I_Flush),
        .O_Busy(O_Busy), .O_Overflow(O_Overflow),
        .O_Count(O_Count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d,
                        input logic a, input logic r,
                        input logic nk, input logic fl);
        logic        pop, wr;
        logic [33:0] e;
        I_Valid = v; I_Data = d; I_Acq = a; I_Rls = r;
        I_Nack_My = nk; I_Flush = fl;
        #1;
        pop = (mcount != 0) && !nk;
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (pop) begin
                e = sb.pop_front();
                chk("pop_word", {30'b0, O_Rls, O_Acq, O_Data}, {30'b0, e});
            end
            wr = v && (mcount < 8 || pop);
            if (v && !wr) movf = 1'b1;
            if (wr) sb.push_back({r, a, d});
            mcount = mcount + int'(wr) - int'(pop);
        end
        mnack = !fl && (mcount >= 6);
        @(posedge clock);
        @(negedge clock);
        chk("count", 64'(O_Count), 64'(mcount));
        chk("valid", 64'(O_Valid), 64'(mcount != 0));
        chk("nack", 64'(O_Nack), 64'(mnack));
        chk("overflow", 64'(O_Overflow), 64'(movf));
        I_Valid = 1'b0; I_Flush = 1'b0; I_Acq = 1'b0; I_Rls = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        I_Data = '0; I_Valid = 0; I_Acq = 0; I_Rls = 0;
        I_Nack_My = 0; I_Flush = 0;
        repeat (2) @(negedge clock);
        chk("rst_valid", 64'(O_Valid), 0);
        chk("rst_count", 64'(O_Count), 0);
        chk("rst_nack", 64'(O_Nack), 0);
        chk("rst_busy", 64'(O_Busy), 0);
        chk("rst_data", 64'(O_Data), 0);
        chk("rst_ovf", 64'(O_Overflow), 0);
        reset = 1'b1;
        @(negedge clock);

        // reset mid-stream
        for (int i = 0; i < 3; i++) step(1, 32'h1 + i, 0, 0, 1, 0);
        reset = 1'b0;
        #1;
        chk("midrst_valid", 64'(O_Valid), 0);
        chk("midrst_count", 64'(O_Count), 0);
        chk("midrst_nack", 64'(O_Nack), 0);
        chk("midrst_busy", 64'(O_Busy), 0);
        sb.delete(); mcount = 0; mnack = 0;
        @(negedge clock);
        reset = 1'b1;
        step(1, 32'hA5, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // streaming
        step(1, 32'h11, 0, 0, 0, 0);
        chk("stream_d0", 64'(O_Data), 64'h11);
        step(1, 32'h22, 0, 0, 0, 0);
        chk("stream_d1", 64'(O_Data), 64'h22);
        chk("stream_cnt", 64'(O_Count <= 1), 1);
        step(1, 32'h33, 0, 0, 0, 0);
        chk("stream_d2", 64'(O_Data), 64'h33);
        chk("stream_cnt", 64'(O_Count <= 1), 1);
        step(0, 0, 0, 0, 0, 0);

        // hold under synchroniser Nack
        for (int i = 0; i < 10; i++) begin
            step(i < 6, 32'h100 + i, 0, 0, 1, 0);
            chk("hold_head", 64'(O_Data), 64'h100);
        end
        chk("hold_nack", 64'(O_Nack), 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

        // overflow
        for (int i = 0; i < 9; i++) step(1, 32'h200 + i, 0, 0, 1, 0);
        chk("ovf_sat", 64'(O_Count), 8);
        chk("ovf_flag", 64'(O_Overflow), 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0);

        // framing
        chk("frame_idle", 64'(O_Busy), 0);
        step(1, 32'hA, 1, 0, 1, 0);
        chk("frame_busyA", 64'(O_Busy), 1);
        chk("frame_acq", 64'(O_Acq), 1);
        step(1, 32'hB, 0, 0, 1, 0);
        step(1, 32'hC, 0, 1, 1, 0);
        chk("frame_busyC", 64'(O_Busy), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("frame_pop1", 64'(O_Busy), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("frame_pop2", 64'(O_Busy), 1);
        chk("frame_rls", 64'(O_Rls), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("frame_done", 64'(O_Busy), 0);

        // flush with concurrent write
        for (int i = 0; i < 5; i++) step(1, 32'h300 + i, 0, 0, 1, 0);
        step(1, 32'hDEAD, 0, 0, 1, 1);
        chk("flush_busy", 64'(O_Busy), 0);
        chk("flush_data", 64'(O_Data), 0);
        step(1, 32'h77, 0, 0, 0, 0);
        chk("flush_next", 64'(O_Data), 64'h77);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_empty", 64'(O_Busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/port_nack_buffer.md
Name: port_nack_buffer

Overview:
- Elastic input stage that sits directly upstream of each ALU port synchroniser.
- Captures the token stream arriving from the link (data word plus Valid/Acq/Rls flags) into a small FIFO.
- Presents the head word to the port synchroniser and holds it while the synchroniser issues its own Nack.
- Asserts a registered Nack back to the link before the FIFO can overflow.
- Tracks packet framing (Acq to Rls) so an empty port is reported idle only between packets.

Parameters:
- WIDTH_DATA, 32, payload word width.
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- WIDTH_DEPTH, $clog2(DEPTH), pointer width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- I_Data  in  WIDTH_DATA  link payload.
- I_Valid  in  1  link Valid token; word written when high.
- I_Acq  in  1  Acq token, qualified by I_Valid.
- I_Rls  in  1  Release token, qualified by I_Valid.
- O_Nack  out  1  Nack to link (registered).
- O_Data  out  WIDTH_DATA  head word to port synchroniser.
- O_Valid  out  1  head word present.
- O_Acq  out  1  head word Acq flag.
- O_Rls  out  1  head word Rls flag.
- I_Nack_My  in  1  synchroniser Nack: head not consumed this cycle.
- I_Flush  in  1  synchronous flush (exec done abort).
- O_Busy  out  1  packet in flight or FIFO non-empty.
- O_Overflow  out  1  sticky: write attempted while full.
- O_Count  out  WIDTH_DEPTH+1  current occupancy.

Behaviour:
- Reset (reset=0, async):
  - Pointers, count, O_Nack, O_Overflow and FSM clear.
  - O_Valid=0, O_Acq=0, O_Rls=0, O_Data=0, O_Busy=0.
- FIFO entry: {Rls, Acq, Data}, width WIDTH_DATA+2.
- Write: I_Valid & ~full stores the word at the tail.
- Read (pop): O_Valid & ~I_Nack_My pops the head at the clock edge.
- Outputs:
  - O_Data/O_Acq/O_Rls are combinational from the head entry.
  - O_Valid = (count != 0).
  - Write-to-O_Valid latency is 1 cycle (no fall-through on empty).
- Simultaneous write and pop: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Full: a write with count==DEPTH and no pop in the same cycle is dropped; O_Overflow sets and stays set until reset. A write while full with a pop in the same cycle is accepted.
- O_Nack (registered):
  - O_Nack <= (next_count >= DEPTH-2).
  - The two-entry skid absorbs the link's one-cycle Nack reaction plus one word in flight.
  - O_Nack deasserts the cycle after next_count < DEPTH-2.
- Nack from synchroniser: I_Nack_My=1 holds the head word stable (data and flags) for any number of cycles. Writes continue.
- Packet FSM, states iDLE, aCTIVE, rLS_PEND, updated on the write side:
  - iDLE -> aCTIVE on an accepted write with Acq=1.
  - aCTIVE -> rLS_PEND on an accepted write with Rls=1.
  - rLS_PEND -> iDLE when that Rls word is popped, tracked by a counter of outstanding Rls entries.
  - A word with both Acq and Rls goes iDLE -> rLS_PEND directly.
  - Words received in iDLE without Acq are still stored (bypass/config traffic).
- O_Busy = (FSM != iDLE) | (count != 0).
- Flush:
  - I_Flush=1 clears pointers, count, the Rls counter and the FSM to iDLE next cycle.
  - Any write in the same cycle is discarded.
  - O_Overflow is unaffected.
  - O_Nack is 0 the following cycle.
- Flush has priority over write and pop. Async reset has priority over everything.

Test Plan:
- Reset mid-stream: load 3 words, assert reset=0 for 1 cycle -> O_Valid=0, O_Count=0, O_Nack=0, O_Busy=0 immediately; first write after release appears on O_Valid after 1 cycle.
- Streaming with I_Nack_My=0, DEPTH=8: write 0x11,0x22,0x33 on consecutive cycles -> O_Data shows 0x11,0x22,0x33 on cycles 1,2,3; O_Count never exceeds 1.
- Hold: I_Nack_My=1 for 10 cycles while 6 words are written -> O_Data stays at first word; O_Nack rises on the cycle after count reaches 6; no overflow; release Nack -> words drain in order.
- Overflow: ignore O_Nack and write 9 words with I_Nack_My=1 -> count saturates at 8, O_Overflow=1; then pop 8 words -> first 8 payloads returned in order.
- Framing: word A with Acq, then B, then C with Rls, all popped -> O_Busy=1 from A's write until the cycle after C pops, then 0; FSM passes iDLE->aCTIVE->rLS_PEND->iDLE.
- Flush with 5 words and a concurrent write -> next cycle O_Count=0, O_Valid=0, O_Busy=0, O_Nack=0; the concurrent word is absent.
